// File: rtl/config_bank_pkg.sv
// Purpose: shared types, default timing and sizing helper for the config bank writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package config_bank_pkg;

    localparam int DEF_NUM_BL    = 8;
    localparam int DEF_NUM_WL    = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_WL_PULSE  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ROW,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Bits needed to index n items (or hold the value n-1), never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Purpose: loadable down-counter with zero flag, shared by the SETUP/PULSE/HOLD phases.
// Latency: load and decrement take effect on the next rising edge; zero is combinational.
// Backpressure: none; the counter saturates at zero instead of wrapping.
// Ports: clk, reset (sync, active-high), load/load_val, dec, count, zero.
module cfg_phase_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/config_bank_writer.sv
// Purpose: drives one row word onto the bit lines, then pulses that row's word line; repeats for every row.
// Latency: 1 + SETUP_CYC + WL_PULSE + HOLD_CYC cycles per row once a row word is offered.
// Backpressure: row_ready is high only in WAIT_ROW; the writer waits there indefinitely for row_valid.
// Ports: clk, reset; start; row_data/row_valid/row_ready handshake; bl, wl (registered); busy, done, row_idx.
module config_bank_writer
    import config_bank_pkg::*;
#(
    parameter int NUM_BL    = DEF_NUM_BL,
    parameter int NUM_WL    = DEF_NUM_WL,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WL_PULSE  = DEF_WL_PULSE,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_BL-1:0]               row_data,
    input  logic                            row_valid,
    output logic                            row_ready,
    output logic [NUM_BL-1:0]               bl,
    output logic [NUM_WL-1:0]               wl,
    output logic                            busy,
    output logic                            done,
    output logic [clog2_min1(NUM_WL)-1:0]   row_idx
);

    localparam int IDX_W = clog2_min1(NUM_WL);
    localparam int TMR_W = clog2_min1(max3(SETUP_CYC, WL_PULSE, HOLD_CYC));

    state_t              state, state_n;
    logic [NUM_BL-1:0]   bl_n;
    logic [NUM_WL-1:0]   wl_n;
    logic                busy_n, done_n;
    logic [IDX_W-1:0]    idx_n;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]    tmr_val, tmr_count;

    cfg_phase_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // The handshake is only open while waiting for a row; anything offered elsewhere is dropped.
    assign row_ready = (state == ST_WAIT_ROW);

    always_comb begin
        state_n  = state;
        bl_n     = bl;
        wl_n     = wl;
        busy_n   = busy;
        done_n   = done;
        idx_n    = row_idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_WAIT_ROW;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            ST_WAIT_ROW: begin
                bl_n = '0;
                wl_n = '0;
                if (row_valid) begin
                    bl_n     = row_data;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETUP_CYC - 1);
                    state_n  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wl_n = '0;
                if (tmr_zero) begin
                    // bl has been stable SETUP_CYC cycles; raise exactly this row's word line.
                    wl_n     = NUM_WL'(1) << row_idx;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(WL_PULSE - 1);
                    state_n  = ST_PULSE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    wl_n     = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYC - 1);
                    state_n  = ST_HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                wl_n = '0;
                if (tmr_zero) begin
                    // wl has been low HOLD_CYC cycles, so releasing bl cannot disturb the latched row.
                    bl_n = '0;
                    if (row_idx == IDX_W'(NUM_WL - 1)) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = row_idx + IDX_W'(1);
                        state_n = ST_WAIT_ROW;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                bl_n    = '0;
                wl_n    = '0;
                busy_n  = 1'b0;
                done_n  = 1'b0;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bl      <= '0;
            wl      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            row_idx <= '0;
        end else begin
            state   <= state_n;
            bl      <= bl_n;
            wl      <= wl_n;
            busy    <= busy_n;
            done    <= done_n;
            row_idx <= idx_n;
        end
    end

endmodule

// File: tb/tb_config_bank_writer.sv
// Purpose: self-checking bench for config_bank_writer across default, stretched and minimal configurations.
// Latency: n/a.
// Backpressure: exercises a row_valid gap ahead of row 3.
module tb_config_bank_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- DUT A: default parameters ----------------
    logic       reset_a = 1'b1;
    logic       a_start = 1'b0;
    logic [7:0] a_row_data = '0;
    logic       a_row_valid = 1'b0;
    logic       a_row_ready;
    logic [7:0] a_bl;
    logic [7:0] a_wl;
    logic       a_busy, a_done;
    logic [2:0] a_row_idx;

    config_bank_writer u_a (
        .clk       (clk),
        .reset     (reset_a),
        .start     (a_start),
        .row_data  (a_row_data),
        .row_valid (a_row_valid),
        .row_ready (a_row_ready),
        .bl        (a_bl),
        .wl        (a_wl),
        .busy      (a_busy),
        .done      (a_done),
        .row_idx   (a_row_idx)
    );

    // ---------------- DUT B: SETUP=3, PULSE=4, HOLD=2, two rows ----------------
    logic       reset_bc = 1'b1;
    logic       b_start = 1'b0;
    logic [7:0] b_row_data = '0;
    logic       b_row_valid = 1'b0;
    logic       b_row_ready;
    logic [7:0] b_bl;
    logic [1:0] b_wl;
    logic       b_busy, b_done;
    logic [0:0] b_row_idx;

    config_bank_writer #(
        .NUM_BL (8), .NUM_WL (2), .SETUP_CYC (3), .WL_PULSE (4), .HOLD_CYC (2)
    ) u_b (
        .clk       (clk),
        .reset     (reset_bc),
        .start     (b_start),
        .row_data  (b_row_data),
        .row_valid (b_row_valid),
        .row_ready (b_row_ready),
        .bl        (b_bl),
        .wl        (b_wl),
        .busy      (b_busy),
        .done      (b_done),
        .row_idx   (b_row_idx)
    );

    // ---------------- DUT C: everything minimal ----------------
    logic       c_start = 1'b0;
    logic [0:0] c_row_data = '0;
    logic       c_row_valid = 1'b0;
    logic       c_row_ready;
    logic [0:0] c_bl;
    logic [0:0] c_wl;
    logic       c_busy, c_done;
    logic [0:0] c_row_idx;

    config_bank_writer #(
        .NUM_BL (1), .NUM_WL (1), .SETUP_CYC (1), .WL_PULSE (1), .HOLD_CYC (1)
    ) u_c (
        .clk       (clk),
        .reset     (reset_bc),
        .start     (c_start),
        .row_data  (c_row_data),
        .row_valid (c_row_valid),
        .row_ready (c_row_ready),
        .bl        (c_bl),
        .wl        (c_wl),
        .busy      (c_busy),
        .done      (c_done),
        .row_idx   (c_row_idx)
    );

    // One record per clock cycle of DUT A: inputs driven that cycle, outputs expected that cycle.
    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic [7:0] bl;
        logic [7:0] wl;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic vl, input logic [7:0] dt, input logic rd,
                                input logic [7:0] b, input logic [7:0] w, input logic bs,
                                input logic dn, input logic [2:0] ix);
        vec_t v;
        v.start = st; v.valid = vl; v.data = dt; v.rdy = rd;
        v.bl = b; v.wl = w; v.busy = bs; v.done = dn; v.idx = ix;
        return v;
    endfunction

    function automatic logic [7:0] row_word(input int r);
        return (r % 2 == 0) ? 8'hA5 : 8'h5A;
    endfunction

    // Default timing per row: WAIT(1) SETUP(1) PULSE(2) HOLD(1). Junk data (FF, valid=1) is offered
    // outside WAIT_ROW and must never reach bl.
    task automatic add_region(input int gap_row, input int gap_len, input int stray_row, input bit from_done);
        logic [7:0] d;
        logic [7:0] oh;
        vq.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, from_done, from_done ? 3'd7 : 3'd0));
        for (int r = 0; r < 8; r++) begin
            d  = row_word(r);
            oh = 8'h01 << r;
            if (r == gap_row) begin
                for (int g = 0; g < gap_len; g++)
                    vq.push_back(mk(1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 3'(r)));
            end
            vq.push_back(mk(1'b0, 1'b1, d,     1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 3'(r)));
            vq.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, d,     8'h00, 1'b1, 1'b0, 3'(r)));
            vq.push_back(mk(r == stray_row, 1'b1, 8'hFF, 1'b0, d, oh, 1'b1, 1'b0, 3'(r)));
            vq.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, d,     oh,    1'b1, 1'b0, 3'(r)));
            vq.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, d,     8'h00, 1'b1, 1'b0, 3'(r)));
        end
        vq.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd7));
        vq.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd7));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        int   r, o;
        logic [7:0] bd;

        add_region(-1, 0, 2, 1'b0);   // basic region with a stray start during row 2
        add_region(3, 7, -1, 1'b1);   // restart from DONE, 7-cycle row_valid gap before row 3

        repeat (2) @(posedge clk);
        @(negedge clk);

        // Outputs while reset is still asserted.
        chk("reset.a_wl", 32'(a_wl), 32'h0);
        chk("reset.a_busy", 32'(a_busy), 32'h0);
        chk("reset.b_ready", 32'(b_row_ready), 32'h0);
        reset_a  = 1'b0;
        reset_bc = 1'b0;

        // ---------------- table-driven run on DUT A ----------------
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            chk($sformatf("v%0d.ready", i), 32'(a_row_ready), 32'(v.rdy));
            chk($sformatf("v%0d.bl", i),    32'(a_bl),        32'(v.bl));
            chk($sformatf("v%0d.wl", i),    32'(a_wl),        32'(v.wl));
            chk($sformatf("v%0d.busy", i),  32'(a_busy),      32'(v.busy));
            chk($sformatf("v%0d.done", i),  32'(a_done),      32'(v.done));
            chk($sformatf("v%0d.idx", i),   32'(a_row_idx),   32'(v.idx));
            a_start     = v.start;
            a_row_valid = v.valid;
            a_row_data  = v.data;
            @(negedge clk);
        end

        // ---------------- reset during the PULSE of row 5 ----------------
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        k = 0;
        while (a_wl !== 8'h20 && k < 200) begin
            a_row_valid = 1'b1;
            a_row_data  = 8'h77;
            @(negedge clk);
            k++;
        end
        chk("rst5.reach_pulse_row5", 32'(a_wl), 32'h20);
        reset_a = 1'b1;
        @(negedge clk);
        chk("rst5.wl",    32'(a_wl),        32'h0);
        chk("rst5.bl",    32'(a_bl),        32'h0);
        chk("rst5.busy",  32'(a_busy),      32'h0);
        chk("rst5.done",  32'(a_done),      32'h0);
        chk("rst5.idx",   32'(a_row_idx),   32'h0);
        chk("rst5.ready", 32'(a_row_ready), 32'h0);
        reset_a = 1'b0;
        @(negedge clk);
        chk("rst5.idle_busy",  32'(a_busy),      32'h0);
        chk("rst5.idle_ready", 32'(a_row_ready), 32'h0);
        chk("rst5.idle_bl",    32'(a_bl),        32'h0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("restart.ready", 32'(a_row_ready), 32'h1);
        chk("restart.idx",   32'(a_row_idx),   32'h0);
        chk("restart.busy",  32'(a_busy),      32'h1);
        a_row_valid = 1'b1;
        a_row_data  = 8'hC3;
        @(negedge clk);
        a_row_data  = 8'hFF;
        chk("restart.setup_bl", 32'(a_bl), 32'hC3);
        chk("restart.setup_wl", 32'(a_wl), 32'h0);
        @(negedge clk);
        chk("restart.pulse1_wl", 32'(a_wl), 32'h01);
        @(negedge clk);
        chk("restart.pulse2_wl", 32'(a_wl), 32'h01);
        chk("restart.pulse2_bl", 32'(a_bl), 32'hC3);
        @(negedge clk);
        chk("restart.hold_wl", 32'(a_wl), 32'h0);
        chk("restart.hold_bl", 32'(a_bl), 32'hC3);
        a_row_valid = 1'b0;
        @(negedge clk);
        chk("restart.row1_ready", 32'(a_row_ready), 32'h1);
        chk("restart.row1_idx",   32'(a_row_idx),   32'h1);
        chk("restart.row1_bl",    32'(a_bl),        32'h0);

        // ---------------- DUT B: stretched timing, 10 cycles per row ----------------
        chk("b.idle_busy", 32'(b_busy), 32'h0);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            r  = (c - 1) / 10;
            o  = (c - 1) % 10;
            bd = (r == 0) ? 8'h3C : 8'hC3;
            chk($sformatf("b.c%0d.ready", c), 32'(b_row_ready), (o == 0) ? 32'h1 : 32'h0);
            chk($sformatf("b.c%0d.bl", c),    32'(b_bl),        (o >= 1) ? 32'(bd) : 32'h0);
            chk($sformatf("b.c%0d.wl", c),    32'(b_wl),
                (o >= 4 && o <= 7) ? ((r == 0) ? 32'h1 : 32'h2) : 32'h0);
            chk($sformatf("b.c%0d.busy", c),  32'(b_busy),      32'h1);
            chk($sformatf("b.c%0d.idx", c),   32'(b_row_idx),   32'(r));
            b_row_valid = 1'b1;
            b_row_data  = bd;
            @(negedge clk);
        end
        b_row_valid = 1'b0;
        chk("b.done",      32'(b_done),    32'h1);
        chk("b.done_busy", 32'(b_busy),    32'h0);
        chk("b.done_idx",  32'(b_row_idx), 32'h1);
        chk("b.done_bl",   32'(b_bl),      32'h0);
        chk("b.done_wl",   32'(b_wl),      32'h0);

        // ---------------- DUT C: single row, single bit, run twice ----------------
        for (int it = 0; it < 2; it++) begin
            chk($sformatf("c%0d.pre_done", it), 32'(c_done), 32'(it));
            chk($sformatf("c%0d.pre_busy", it), 32'(c_busy), 32'h0);
            c_start = 1'b1;
            @(negedge clk);
            c_start = 1'b0;
            chk($sformatf("c%0d.wait_ready", it), 32'(c_row_ready), 32'h1);
            chk($sformatf("c%0d.wait_busy", it),  32'(c_busy),      32'h1);
            chk($sformatf("c%0d.wait_done", it),  32'(c_done),      32'h0);
            c_row_valid = 1'b1;
            c_row_data  = 1'b1;
            @(negedge clk);
            c_row_data  = 1'b0;
            chk($sformatf("c%0d.setup_bl", it), 32'(c_bl), 32'h1);
            chk($sformatf("c%0d.setup_wl", it), 32'(c_wl), 32'h0);
            @(negedge clk);
            chk($sformatf("c%0d.pulse_wl", it), 32'(c_wl), 32'h1);
            chk($sformatf("c%0d.pulse_bl", it), 32'(c_bl), 32'h1);
            @(negedge clk);
            chk($sformatf("c%0d.hold_wl", it), 32'(c_wl), 32'h0);
            chk($sformatf("c%0d.hold_bl", it), 32'(c_bl), 32'h1);
            c_row_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("c%0d.done_bl", it),  32'(c_bl),      32'h0);
            chk($sformatf("c%0d.done_idx", it), 32'(c_row_idx), 32'h0);
        end
        chk("c.final_done", 32'(c_done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/config_bank_writer.md
Name: config_bank_writer

Overview:
- Write-side driver for the memory-bank configuration fabric.
- Takes one row word per handshake from the bitstream loader.
- Drives the bit-line bus with that word, then pulses the matching word line one-hot. This writes one row of `config_latch` cells.
- Sits between the bitstream source and the BL/WL distribution of a configuration region. Sequences all `NUM_WL` rows, then reports completion.

Parameters:
- NUM_BL, 8, bit-line count; width of one row word (≥1)
- NUM_WL, 8, word-line count; rows per region (≥1)
- SETUP_CYC, 1, cycles BL is stable before WL rises (≥1)
- WL_PULSE, 2, cycles WL is held high (≥1)
- HOLD_CYC, 1, cycles BL is held after WL falls (≥1)

Ports:
- clk  input  1  configuration clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to program a full region; honoured only in IDLE or DONE
- row_data  input  NUM_BL  row word for the current row
- row_valid  input  1  row_data valid
- row_ready  output  1  writer accepts a row this cycle
- bl  output  NUM_BL  bit-line drive, registered
- wl  output  NUM_WL  word-line drive, registered, one-hot or zero
- busy  output  1  high from start acceptance until DONE entry
- done  output  1  high in DONE until next start or reset
- row_idx  output  clog2(NUM_WL) (min 1)  current row index

Behaviour:
- Reset (sync, priority over all inputs): state=IDLE; bl=0, wl=0, row_ready=0, busy=0, done=0, row_idx=0 on the edge where reset=1. wl must never carry a non-zero value on that cycle.
- States: IDLE, WAIT_ROW, SETUP, PULSE, HOLD, DONE.
- IDLE / DONE:
  - start=1 → WAIT_ROW, row_idx=0, busy=1, done=0.
  - start=0 → stay.
- WAIT_ROW:
  - row_ready=1 (combinational from state); bl=0, wl=0.
  - On row_valid & row_ready: bl ← row_data, timer ← SETUP_CYC-1, → SETUP.
  - row_valid low → wait indefinitely.
- SETUP: bl held, wl=0. When timer=0, go to PULSE: wl ← one-hot(row_idx), timer ← WL_PULSE-1. Otherwise decrement timer.
- PULSE: wl held one-hot. When timer=0, go to HOLD: wl ← 0, timer ← HOLD_CYC-1. Otherwise decrement timer.
- HOLD: bl held, wl=0. When timer=0:
  - bl ← 0.
  - If row_idx=NUM_WL-1 → DONE: busy ← 0, done ← 1, row_idx kept.
  - Otherwise row_idx ← row_idx+1 → WAIT_ROW.
  - Otherwise (timer≠0) decrement timer.
- Timing per row, with the accept edge at T:
  - bl valid from T+1.
  - wl high for cycles T+1+SETUP_CYC … T+SETUP_CYC+WL_PULSE.
  - bl cleared after HOLD_CYC more cycles.
  - Next row_ready at T+1+SETUP_CYC+WL_PULSE+HOLD_CYC.
  - Defaults: 5 cycles/row with data always valid; 40 cycles/region.
- Invariants:
  - At most one wl bit is high.
  - bl changes only when wl=0.
  - wl is zero outside PULSE.
- start is ignored while busy; it is not queued. row_valid is ignored outside WAIT_ROW; no data is captured.
- Reset mid-PULSE: wl=0 on the reset edge; the region restarts only on a new start.
- Widths: the timer is sized to max(SETUP_CYC, WL_PULSE, HOLD_CYC)-1, minimum 1 bit. Row wrap occurs only via DONE; row_idx never exceeds NUM_WL-1.

Decomposition:
- Shared package `config_bank_pkg`:
  - state enum (IDLE, WAIT_ROW, SETUP, PULSE, HOLD, DONE)
  - function clog2_min1
  - default timing constants
- One sub-module, `cfg_phase_timer`: a loadable down-counter with a zero flag, reused for all three phases.

Test Plan:
- Basic region, defaults, NUM_WL=8, row_valid always 1, row_data=8'hA5,8'h5A,…:
  - wl goes 8'h01 for 2 cycles, then 8'h02, and so on.
  - bl=8'hA5 one cycle before wl=8'h01.
  - done rises 40 cycles after start; busy falls on the same edge.
- Backpressure, row_valid low 7 cycles before row 3:
  - row_ready stays high 7 cycles.
  - bl=0 and wl=0 throughout the gap.
  - Row 3 timing is then identical to the other rows.
- Timing parameters SETUP_CYC=3, WL_PULSE=4, HOLD_CYC=2:
  - wl high exactly 4 cycles, starting 3 cycles after bl loads.
  - Per row = 10 cycles.
- start asserted during row 2: ignored; row_idx and sequence unchanged; done rises once.
- reset asserted during PULSE of row 5:
  - next cycle wl=0, bl=0, busy=0, done=0, row_idx=0.
  - a new start reprograms from row 0.
- NUM_WL=1, NUM_BL=1, SETUP_CYC=WL_PULSE=HOLD_CYC=1, row_data=1: single 1-cycle wl pulse; done after 4 cycles; a second start repeats the sequence.
